// File: rtl/ram_pkg.sv
// Shared types for the simple-dual-port init RAM: FSM state encoding and
// read-during-write mode selectors.
package ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_sdp_init_if.sv
// Bus bundle for ram_sdp_init: write port, read port, output enable and status.
interface ram_sdp_init_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) ();

  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  oe;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  init_busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, oe,
    input  rd_data, rd_valid, init_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, oe,
    output rd_data, rd_valid, init_busy
  );

endinterface

// File: rtl/ram_be_merge.sv
// Combinational byte-enable merge: each enabled byte comes from new_data,
// the rest from old_data.
module ram_be_merge #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0]   old_data,
  input  logic [DATA_W-1:0]   new_data,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);

  always_comb begin
    merged = old_data;
    for (int k = 0; k < DATA_W/8; k++) begin
      if (be[k]) merged[8*k +: 8] = new_data[8*k +: 8];
    end
  end

endmodule

// File: rtl/ram_sdp_init.sv
// Simple-dual-port RAM with byte enables, selectable read-during-write and a
// clear sweep after reset. Define RAM_SDP_OUT_REG_EN for a 2-cycle read latency.
module ram_sdp_init
  import ram_pkg::*;
#(
  parameter int               DATA_W   = 16,
  parameter int               ADDR_W   = 8,
  parameter int               RDW_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic            clk,
  input logic            rst,
  ram_sdp_init_if.slave  bus
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic              rd_v;
  logic              busy_q;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] rd_word;
  logic              running;
  logic              collide;

  assign running = (state == ST_RUN);
  assign collide = running && bus.wr_en && bus.rd_en && (bus.wr_addr == bus.rd_addr);

  ram_be_merge #(.DATA_W(DATA_W)) u_merge (
    .old_data (mem[bus.wr_addr]),
    .new_data (bus.wr_data),
    .be       (bus.wr_be),
    .merged   (wr_merged)
  );

  // Write-first collisions bypass the array so the read sees the merged word.
  assign rd_word = (RDW_MODE == RDW_WRITE_FIRST && collide) ? wr_merged : mem[bus.rd_addr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT)             mem[ptr]         <= INIT_VAL;
      else if (running && bus.wr_en)    mem[bus.wr_addr] <= wr_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_INIT;
      ptr    <= '0;
      rd_v   <= 1'b0;
      rd_q   <= '0;
      busy_q <= 1'b1;
    end else if (state == ST_INIT) begin
      ptr  <= ptr + 1'b1;
      rd_v <= 1'b0;
      if (ptr == LAST) begin
        state  <= ST_RUN;
        busy_q <= 1'b0;
      end
    end else begin
      rd_v <= bus.rd_en;
      if (bus.rd_en) rd_q <= rd_word;
    end
  end

`ifdef RAM_SDP_OUT_REG_EN
  logic [DATA_W-1:0] out_q;
  logic              out_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      out_v <= 1'b0;
    end else begin
      out_v <= rd_v;
      if (rd_v) out_q <= rd_q;
    end
  end

  assign bus.rd_data  = bus.oe ? out_q : '0;
  assign bus.rd_valid = out_v;
`else
  assign bus.rd_data  = bus.oe ? rd_q : '0;
  assign bus.rd_valid = rd_v;
`endif

  assign bus.init_busy = busy_q;

endmodule

// File: tb/tb_ram_sdp_init.sv
// Scoreboard bench for ram_sdp_init (16x16, INIT_VAL A5A5); honours RAM_SDP_OUT_REG_EN.
module tb_ram_sdp_init;

  parameter int RDW_MODE = 0;

`ifdef RAM_SDP_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [15:0] data;
    int          due;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  exp_t sb[$];

  logic [15:0] wdata [10] = '{16'h3C5A, 16'h9E01, 16'h7714, 16'hD2B8, 16'h0F0F,
                              16'h6A93, 16'hF00D, 16'h1C2E, 16'h8B47, 16'h52E6};

  ram_sdp_init_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  ram_sdp_init #(
    .DATA_W   (16),
    .ADDR_W   (4),
    .RDW_MODE (RDW_MODE),
    .INIT_VAL (16'hA5A5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("[TB] FAIL stray_valid: got rd_valid=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput({e.name, "_data"}, 32'(bus.rd_data), 32'(e.data));
        checkOutput({e.name, "_lat"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                               input logic [1:0] be, input logic re, input logic [3:0] ra,
                               input logic [15:0] exp, input string name);
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.wr_be   = be;
    bus.rd_en   = re;
    bus.rd_addr = ra;
    if (re) sb.push_back('{data: exp, due: cyc + LAT, name: name});
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  // Counts busy cycles from reset release; optionally fires ignored requests mid-sweep.
  task automatic waitSweep(input string name, input bit pulse);
    int cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.init_busy !== 1'b1) break;
      cnt++;
      if (pulse && cnt == 8) begin
        bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 16'h1111; bus.wr_be = 2'b11;
        bus.rd_en = 1'b1; bus.rd_addr = 4'd2;
      end else begin
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    checkOutput(name, 32'(cnt), 32'd16);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.oe = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(bus.init_busy), 32'd1);
    checkOutput("reset_valid", 32'(bus.rd_valid), 32'd0);
    rst = 1'b0;
    waitSweep("sweep_len", 1'b1);

    for (int a = 0; a < 16; a++)
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'(a), 16'hA5A5, $sformatf("sweep_rd%0d", a));
    drain();

    for (int a = 0; a < 10; a++)
      applyStimulus(1'b1, 4'(a), wdata[a], 2'b11, 1'b0, '0, '0, "wr");
    for (int a = 0; a < 10; a++)
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'(a), wdata[a], $sformatf("rb%0d", a));
    drain();

    applyStimulus(1'b1, 4'd3, 16'h1234, 2'b11, 1'b0, '0, '0, "wr");
    applyStimulus(1'b1, 4'd3, 16'hABCD, 2'b10, 1'b0, '0, '0, "wr");
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd3, 16'hAB34, "byte_en");
    drain();

    applyStimulus(1'b1, 4'd5, 16'h0000, 2'b11, 1'b0, '0, '0, "wr");
    applyStimulus(1'b1, 4'd5, 16'hBEEF, 2'b01, 1'b1, 4'd5,
                  (RDW_MODE == 1) ? 16'h00EF : 16'h0000, "collide");
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd5, 16'h00EF, "after_collide");
    drain();

    applyStimulus(1'b1, 4'd7, 16'hCAFE, 2'b11, 1'b0, '0, '0, "wr");
    bus.oe = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd7, 16'h0000, "oe_low");
    drain();
    bus.oe = 1'b1;
    #1;
    checkOutput("oe_restore", 32'(bus.rd_data), 32'h0000CAFE);
    checkOutput("oe_valid_low", 32'(bus.rd_valid), 32'd0);

    // Read issued, then reset lands one cycle later; only a 1-cycle pipe delivers it.
    @(posedge clk);
    #1;
    bus.rd_en = 1'b1;
    bus.rd_addr = 4'd9;
`ifndef RAM_SDP_OUT_REG_EN
    sb.push_back('{data: wdata[9], due: cyc + LAT, name: "midrst_rd"});
`endif
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("midrst_busy", 32'(bus.init_busy), 32'd1);
    rst = 1'b0;
    waitSweep("resweep_len", 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd9, 16'hA5A5, "resweep_rd9");
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd3, 16'hA5A5, "resweep_rd3");
    drain();
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
